// File: rtl/textcon_writer.sv
// Character-stream front end for the text console: cursor tracking, control codes, scrolling and clears.
// Optional feature macro: TEXTCON_WRITER_AUTOWRAP_EN (implicit newline after writing the last column).
module textcon_writer #(
  parameter int         COLS   = 240,
  parameter int         ROWS   = 67,
  parameter int         ADDR_W = 14,
  parameter logic [7:0] ATTR   = 8'h0F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic [7:0]        cur_col,
  output logic [6:0]        cur_row,
  output logic [6:0]        scroll_base,
  output logic              busy
);

  localparam logic [7:0]        LAST_COL = 8'(COLS - 1);
  localparam logic [6:0]        LAST_ROW = 7'(ROWS - 1);
  localparam logic [7:0]        ROWS_W   = 8'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] CELLS    = ADDR_W'(COLS * ROWS);
  localparam logic [15:0]       BLANK    = {ATTR, 8'h20};

  typedef enum logic [1:0] {IDLE, STEP, CLR_LINE, CLR_ALL} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [7:0]        row_sum;
  logic [6:0]        phys_row;
  logic [ADDR_W-1:0] row_base;
  logic [6:0]        next_base;
  logic              printable;
  logic              newline;

  // Both operands are below ROWS, so one conditional subtract gives the modulo.
  always_comb begin
    row_sum   = {1'b0, cur_row} + {1'b0, scroll_base};
    phys_row  = (row_sum >= ROWS_W) ? 7'(row_sum - ROWS_W) : row_sum[6:0];
    row_base  = ADDR_W'(phys_row) * COLS_A;
    next_base = (scroll_base == LAST_ROW) ? 7'd0 : scroll_base + 7'd1;
    printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
`ifdef TEXTCON_WRITER_AUTOWRAP_EN
    newline   = (in_data == 8'h0A) || (printable && (cur_col == LAST_COL));
`else
    newline   = (in_data == 8'h0A);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CLR_ALL;
      clr_cnt     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      cur_col     <= '0;
      cur_row     <= '0;
      scroll_base <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          wr_en <= 1'b0;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            clr_cnt  <= '0;
            state    <= STEP;
            if (printable) begin
              wr_en   <= 1'b1;
              wr_addr <= row_base + ADDR_W'(cur_col);
              wr_data <= {ATTR, in_data};
              if (cur_col != LAST_COL) cur_col <= cur_col + 8'd1;
            end else begin
              case (in_data)
                8'h0D: cur_col <= '0;
                8'h08: if (cur_col != 8'd0) cur_col <= cur_col - 8'd1;
                8'h0C: begin
                  cur_col     <= '0;
                  cur_row     <= '0;
                  scroll_base <= '0;
                  busy        <= 1'b1;
                  state       <= CLR_ALL;
                end
                default: ;
              endcase
            end
            // Later assignments override the column update above for LF and wraps.
            if (newline) begin
              cur_col <= '0;
              if (cur_row != LAST_ROW) begin
                cur_row <= cur_row + 7'd1;
              end else begin
                scroll_base <= next_base;
                busy        <= 1'b1;
                state       <= CLR_LINE;
              end
            end
          end
        end
        STEP: begin
          wr_en    <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        CLR_LINE, CLR_ALL: begin
          if (clr_cnt == ((state == CLR_LINE) ? COLS_A : CELLS)) begin
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= (state == CLR_LINE) ? row_base + clr_cnt : clr_cnt;
            wr_data <= BLANK;
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_textcon_writer.sv
// Bench for textcon_writer: table vectors, random byte stream against a screen model, and corner sequences.
// Honours TEXTCON_WRITER_AUTOWRAP_EN in its reference model.
module tb_textcon_writer;

  localparam int         COLS   = 240;
  localparam int         ROWS   = 67;
  localparam int         ADDR_W = 14;
  localparam int         CELLS  = COLS * ROWS;
  localparam int         LIMIT  = 20000;
  localparam logic [7:0] ATTR   = 8'h0F;

  logic              clk;
  logic              rst_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic [7:0]        cur_col;
  logic [6:0]        cur_row;
  logic [6:0]        scroll_base;
  logic              busy;

  textcon_writer dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cur_col(cur_col),
    .cur_row(cur_row), .scroll_base(scroll_base), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit aborted = 0;

  // Reference screen state and the writes it predicts for the current byte.
  int          m_col, m_row, m_base;
  bit          exp_clear;
  int          exp_addr[$];
  logic [15:0] exp_data[$];
  int          got_addr[$];
  logic [15:0] got_data[$];

  typedef struct {
    logic [7:0]  data;
    int          col;
    int          row;
    int          base;
    int          nwr;
    int          addr;
    logic [15:0] wdata;
  } vec_t;

  vec_t tbl[13];

  task automatic checkOutput(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic model_newline();
    m_col = 0;
    if (m_row < ROWS - 1) m_row++;
    else begin
      m_base = (m_base + 1) % ROWS;
      exp_clear = 1;
      for (int c = 0; c < COLS; c++) begin
        exp_addr.push_back(((ROWS - 1 + m_base) % ROWS) * COLS + c);
        exp_data.push_back({ATTR, 8'h20});
      end
    end
  endtask

  task automatic model_reset();
    exp_addr.delete();
    exp_data.delete();
    m_col = 0; m_row = 0; m_base = 0; exp_clear = 1;
    for (int a = 0; a < CELLS; a++) begin
      exp_addr.push_back(a);
      exp_data.push_back({ATTR, 8'h20});
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_addr.delete();
    exp_data.delete();
    exp_clear = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_addr.push_back(((m_row + m_base) % ROWS) * COLS + m_col);
      exp_data.push_back({ATTR, b});
      if (m_col < COLS - 1) m_col++;
`ifdef TEXTCON_WRITER_AUTOWRAP_EN
      else model_newline();
`endif
    end else begin
      case (b)
        8'h0D: m_col = 0;
        8'h0A: model_newline();
        8'h08: if (m_col > 0) m_col--;
        8'h0C: model_reset();
        default: ;
      endcase
    end
  endtask

  // Collects every write until in_ready returns and compares against the model.
  task automatic checkTransaction(input string name);
    int cyc = 0;
    int bad = 0;
    int bad_busy = 0;
    int n;
    bit done = 0;
    got_addr.delete();
    got_data.delete();
    if (aborted) return;
    while (!done) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b0;
      if (in_ready) done = 1;
      else begin
        if (wr_en) begin
          got_addr.push_back(int'(wr_addr));
          got_data.push_back(wr_data);
          if (!busy) bad_busy++;
        end
        if (cyc >= LIMIT) begin
          done = 1;
          aborted = 1;
          checkOutput({name, "_ready_timeout"}, int'(in_ready), 1);
        end
      end
    end
    checkOutput({name, "_nwr"}, got_addr.size(), exp_addr.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++)
      if (got_addr[i] != exp_addr[i] || got_data[i] !== exp_data[i]) bad++;
    checkOutput({name, "_cells"}, bad, 0);
    checkOutput({name, "_wr_en_idle"}, int'(wr_en), 0);
    checkOutput({name, "_busy_idle"}, int'(busy), 0);
    checkOutput({name, "_col"}, int'(cur_col), m_col);
    checkOutput({name, "_row"}, int'(cur_row), m_row);
    checkOutput({name, "_base"}, int'(scroll_base), m_base);
    if (exp_clear) checkOutput({name, "_busy_clr"}, bad_busy, 0);
    else checkOutput({name, "_latency"}, cyc, 2);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int t = 0;
    if (aborted) return;
    model_byte(b);
    while (!in_ready && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      aborted = 1;
      checkOutput("ready_wait_timeout", int'(in_ready), 1);
      return;
    end
    in_data  = b;
    in_valid = 1'b1;
    checkTransaction($sformatf("byte%02h", b));
  endtask

  task automatic checkResetValues(input string p);
    checkOutput({p, "_wr_en"}, int'(wr_en), 0);
    checkOutput({p, "_wr_addr"}, int'(wr_addr), 0);
    checkOutput({p, "_wr_data"}, int'(wr_data), 0);
    checkOutput({p, "_cur_col"}, int'(cur_col), 0);
    checkOutput({p, "_cur_row"}, int'(cur_row), 0);
    checkOutput({p, "_scroll_base"}, int'(scroll_base), 0);
    checkOutput({p, "_in_ready"}, int'(in_ready), 0);
    checkOutput({p, "_busy"}, int'(busy), 1);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    logic [7:0] b;
    tbl[0]  = '{8'h41, 1, 0, 0, 1, 0,   16'h0F41};
    tbl[1]  = '{8'h08, 0, 0, 0, 0, 0,   16'h0000};
    tbl[2]  = '{8'h08, 0, 0, 0, 0, 0,   16'h0000};
    tbl[3]  = '{8'h42, 1, 0, 0, 1, 0,   16'h0F42};
    tbl[4]  = '{8'h0A, 0, 1, 0, 0, 0,   16'h0000};
    tbl[5]  = '{8'h43, 1, 1, 0, 1, 240, 16'h0F43};
    tbl[6]  = '{8'h0D, 0, 1, 0, 0, 0,   16'h0000};
    tbl[7]  = '{8'h01, 0, 1, 0, 0, 0,   16'h0000};
    tbl[8]  = '{8'h7F, 0, 1, 0, 0, 0,   16'h0000};
    tbl[9]  = '{8'h7E, 1, 1, 0, 1, 240, 16'h0F7E};
    tbl[10] = '{8'h20, 2, 1, 0, 1, 241, 16'h0F20};
    tbl[11] = '{8'h1F, 2, 1, 0, 0, 0,   16'h0000};
    tbl[12] = '{8'h09, 2, 1, 0, 0, 0,   16'h0000};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    checkResetValues("reset");
    #10 rst_n = 1'b1;
    model_reset();
    checkTransaction("power_on_clear");

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].data);
      checkOutput($sformatf("tbl%0d_col", i), int'(cur_col), tbl[i].col);
      checkOutput($sformatf("tbl%0d_row", i), int'(cur_row), tbl[i].row);
      checkOutput($sformatf("tbl%0d_base", i), int'(scroll_base), tbl[i].base);
      checkOutput($sformatf("tbl%0d_nwr", i), got_addr.size(), tbl[i].nwr);
      if (tbl[i].nwr > 0 && got_addr.size() > 0) begin
        checkOutput($sformatf("tbl%0d_addr", i), got_addr[0], tbl[i].addr);
        checkOutput($sformatf("tbl%0d_data", i), int'(got_data[0]), int'(tbl[i].wdata));
      end
    end

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) b = 8'h0A;
      else if (r < 15) b = 8'h0D;
      else if (r < 22) b = 8'h08;
      else if (r < 27) b = 8'($urandom_range(128, 255));
      else if (r < 30) b = 8'h1B;
      else b = 8'($urandom_range(32, 126));
      applyStimulus(b);
    end

    // Form feed back to home, then walk to the bottom and scroll.
    applyStimulus(8'h0C);
    for (int i = 0; i < 66; i++) applyStimulus(8'h0A);
    checkOutput("lf66_row", int'(cur_row), 66);
    applyStimulus(8'h0A);
    checkOutput("scroll1_base", int'(scroll_base), 1);
    checkOutput("scroll1_row", int'(cur_row), 66);
    if (got_addr.size() == COLS) begin
      checkOutput("scroll1_first", got_addr[0], 0);
      checkOutput("scroll1_last", got_addr[COLS-1], 239);
    end

    for (int i = 0; i < 37; i++) applyStimulus(8'(8'h61 + i % 26));
    checkOutput("col37", int'(cur_col), 37);
    applyStimulus(8'h0D);
    checkOutput("cr_col", int'(cur_col), 0);

    for (int i = 0; i < 65; i++) applyStimulus(8'h0A);
    checkOutput("base66", int'(scroll_base), 66);
    for (int i = 0; i < 5; i++) applyStimulus(8'h61);
    applyStimulus(8'h58);
    if (got_addr.size() > 0) begin
      checkOutput("wrap_put_addr", got_addr[0], 15605);
      checkOutput("wrap_put_data", int'(got_data[0]), 16'h0F58);
    end
    applyStimulus(8'h0D);
    applyStimulus(8'h0A);
    checkOutput("base_wrap", int'(scroll_base), 0);
    if (got_addr.size() > 0) checkOutput("base_wrap_clr_addr", got_addr[0], 15840);

    // Reset in the middle of a line clear.
    if (!aborted) begin
      in_data = 8'h0A; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (40) @(negedge clk);
      checkOutput("midclr_busy", int'(busy), 1);
      checkOutput("midclr_wr_en", int'(wr_en), 1);
      #2 rst_n = 1'b0;
      #1 checkResetValues("midclr_reset");
      @(negedge clk);
      #2 rst_n = 1'b1;
      model_reset();
      checkTransaction("reclear");
    end

    for (int i = 0; i < 3; i++) applyStimulus(8'h0A);
    for (int i = 0; i < 240; i++) applyStimulus(8'(8'h41 + i % 26));
`ifdef TEXTCON_WRITER_AUTOWRAP_EN
    checkOutput("line240_row", int'(cur_row), 4);
    checkOutput("line240_col", int'(cur_col), 0);
`else
    checkOutput("line240_row", int'(cur_row), 3);
    checkOutput("line240_col", int'(cur_col), 239);
`endif
    for (int i = 0; i < 3; i++) applyStimulus(8'h7A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
